jtframe_joy_md6: RTL and testbench



---
 rtl/jtframe_joy_md6.sv | 164 ++++++++++++++++
 tb/tb_jtframe_joy_md6.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_joy_md6.sv
// Mega Drive 3/6-button pad scanner for two DB9 ports sharing one select line.
// Demultiplexes the time-shared pins into 12 stable active-low buttons per player.
module jtframe_joy_md6 #(
  parameter int SEL_CYCLES  = 480,
  parameter int POLL_CYCLES = 96000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [5:0]  joy1_bus,
  input  logic [5:0]  joy2_bus,
  output logic        joy_select,
  output logic [11:0] joy1_out,
  output logic [11:0] joy2_out,
  output logic [1:0]  md_det,
  output logic [1:0]  six_det,
  output logic        scan_done
);

  localparam int PW = $clog2(POLL_CYCLES + 1);
  localparam int SW = $clog2(SEL_CYCLES + 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
  localparam logic [SW-1:0] SEL_LAST  = SW'(SEL_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_LATCH = 2'd2
  } state_e;

  state_e         state_q;
  logic [PW-1:0]  poll_q;
  logic [SW-1:0]  cnt_q;
  logic [2:0]     ph_q;
  logic           sel_q;
  logic           done_q;
  logic [11:0]    sh_q  [2];
  logic [11:0]    out_q [2];
  logic [1:0]     md_q;
  logic [1:0]     six_q;
  logic [1:0]     mdo_q;
  logic [1:0]     sixo_q;
  logic [5:0]     bus_s [2];

  assign bus_s[0] = joy1_bus;
  assign bus_s[1] = joy2_bus;

  // Unused button groups read back as released for pads that cannot report them.
  function automatic logic [11:0] fold_shadow(input logic [11:0] sh, input logic md,
                                              input logic six);
    logic [11:0] r;
    r = sh;
    if (!md) begin
      r[11:6] = 6'h3f;
    end else if (!six) begin
      r[11:8] = 4'hf;
    end else begin
      r = sh;
    end
    return r;
  endfunction

  // Scan sequencer: select timing, per-phase sampling and output latching.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      poll_q  <= '0;
      cnt_q   <= '0;
      ph_q    <= 3'd0;
      sel_q   <= 1'b1;
      done_q  <= 1'b0;
      md_q    <= 2'b00;
      six_q   <= 2'b00;
      mdo_q   <= 2'b00;
      sixo_q  <= 2'b00;
      for (int p = 0; p < 2; p++) begin
        sh_q[p]  <= 12'hfff;
        out_q[p] <= 12'hfff;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          sel_q <= 1'b1;
          if (!en) begin
            poll_q <= '0;
            mdo_q  <= 2'b00;
            sixo_q <= 2'b00;
            for (int p = 0; p < 2; p++) begin
              out_q[p] <= {6'h3f, bus_s[p]};
            end
          end else if (poll_q == POLL_LAST) begin
            poll_q  <= '0;
            ph_q    <= 3'd0;
            cnt_q   <= SEL_LAST;
            state_q <= ST_SCAN;
          end else begin
            poll_q <= poll_q + PW'(1);
          end
        end
        ST_SCAN: begin
          if (cnt_q == '0) begin
            for (int p = 0; p < 2; p++) begin
              case (ph_q)
                3'd0: sh_q[p][5:0] <= bus_s[p];
                3'd1: begin
                  md_q[p]      <= (bus_s[p][1:0] == 2'b00);
                  sh_q[p][6]   <= bus_s[p][4];
                  sh_q[p][7]   <= bus_s[p][5];
                end
                3'd5: six_q[p] <= md_q[p] && (bus_s[p][3:0] == 4'h0);
                3'd6: begin
                  if (six_q[p]) begin
                    sh_q[p][8]  <= bus_s[p][3];
                    sh_q[p][9]  <= bus_s[p][2];
                    sh_q[p][10] <= bus_s[p][1];
                    sh_q[p][11] <= bus_s[p][0];
                  end else begin
                    sh_q[p][11:8] <= sh_q[p][11:8];
                  end
                end
                default: sh_q[p] <= sh_q[p];
              endcase
            end
            cnt_q <= SEL_LAST;
            if (ph_q == 3'd7) begin
              sel_q   <= 1'b1;
              state_q <= ST_LATCH;
            end else begin
              // next phase p+1 is odd (select low) exactly when p is even
              sel_q <= ph_q[0];
              ph_q  <= ph_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q - SW'(1);
          end
        end
        ST_LATCH: begin
          for (int p = 0; p < 2; p++) begin
            out_q[p] <= fold_shadow(sh_q[p], md_q[p], six_q[p]);
          end
          mdo_q   <= md_q;
          sixo_q  <= six_q & md_q;
          done_q  <= 1'b1;
          sel_q   <= 1'b1;
          poll_q  <= '0;
          state_q <= ST_IDLE;
        end
        default: begin
          sel_q   <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign joy_select = sel_q;
  assign joy1_out   = out_q[0];
  assign joy2_out   = out_q[1];
  assign md_det     = mdo_q;
  assign six_det    = sixo_q;
  assign scan_done  = done_q;

endmodule

// File: tb/tb_jtframe_joy_md6.sv
// Scoreboard bench for jtframe_joy_md6 with Atari, 3-button and 6-button pad models.
module tb_jtframe_joy_md6;

  localparam int SEL  = 8;
  localparam int POLL = 100;
  localparam int SCAN_T = POLL + 8 * SEL + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic [5:0]  joy1_bus, joy2_bus;
  logic        joy_select;
  logic [11:0] joy1_out, joy2_out;
  logic [1:0]  md_det, six_det;
  logic        scan_done;

  jtframe_joy_md6 #(.SEL_CYCLES(SEL), .POLL_CYCLES(POLL)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .joy1_bus(joy1_bus), .joy2_bus(joy2_bus),
    .joy_select(joy_select), .joy1_out(joy1_out), .joy2_out(joy2_out),
    .md_det(md_det), .six_det(six_det), .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  // Pad models: kind 0 = plain Atari (raw bus), 1 = MD 3-button, 2 = MD 6-button.
  int          kind1 = 0, kind2 = 0;
  logic [5:0]  raw1 = 6'h3f, raw2 = 6'h3f;
  logic [11:0] btn1 = 12'hfff, btn2 = 12'hfff;
  int          ph = 0, hi_cnt = 0;
  logic        sel_prev = 1'b1;

  function automatic logic [5:0] pad_bus(input int kind, input logic [5:0] raw,
                                         input logic [11:0] b, input logic sel, input int p);
    logic [5:0] r;
    if (kind == 0) r = raw;
    else if (sel && kind == 2 && p == 6) r = {b[5], b[4], b[8], b[9], b[10], b[11]};
    else if (sel) r = {b[5], b[4], b[3:0]};
    else if (kind == 2 && p == 5) r = {b[7], b[6], 4'b0000};
    else r = {b[7], b[6], b[3], b[2], 2'b00};
    return r;
  endfunction

  // 6-button pad counts select edges and forgets them after a long high period.
  always @(posedge clk) begin
    sel_prev <= joy_select;
    hi_cnt   <= joy_select ? ((hi_cnt < 1000) ? hi_cnt + 1 : hi_cnt) : 0;
    if (joy_select && hi_cnt >= 40) ph <= 0;
    else if (joy_select !== sel_prev) ph <= ph + 1;
  end

  always_comb begin
    joy1_bus = pad_bus(kind1, raw1, btn1, joy_select, ph);
    joy2_bus = pad_bus(kind2, raw2, btn2, joy_select, ph);
  end

  typedef struct packed {
    logic [11:0] j1;
    logic [11:0] j2;
    logic [1:0]  md;
    logic [1:0]  six;
  } exp_t;
  exp_t sb_q[$];
  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [11:0] j1, input logic [11:0] j2,
                      input logic [1:0] md, input logic [1:0] six);
    exp_t e;
    e.j1 = j1; e.j2 = j2; e.md = md; e.six = six;
    sb_q.push_back(e);
  endtask

  // Monitor: every scan_done pulse is matched against the oldest expectation.
  always @(posedge clk) begin : mon
    exp_t e;
    #1;
    if (scan_done === 1'b1) begin
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("sb_joy1", {20'h0, joy1_out}, {20'h0, e.j1});
        check("sb_joy2", {20'h0, joy2_out}, {20'h0, e.j2});
        check("sb_md",   {30'h0, md_det},   {30'h0, e.md});
        check("sb_six",  {30'h0, six_det},  {30'h0, e.six});
      end else begin
        check("sb_unexpected_done", {31'h0, scan_done}, 32'h0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic measure_scan(output int t_fall, output int n_tog, output int t_done,
                              output int n_glitch);
    logic        prev_s;
    logic [27:0] prev_o;
    t_fall = -1; n_tog = 0; t_done = -1; n_glitch = 0;
    prev_s = joy_select;
    prev_o = {joy1_out, joy2_out, md_det, six_det};
    for (int c = 1; c <= 2000; c++) begin
      step();
      if (joy_select !== prev_s) begin
        n_tog++;
        if (t_fall < 0) t_fall = c;
      end
      prev_s = joy_select;
      if (scan_done !== 1'b1 && {joy1_out, joy2_out, md_det, six_det} !== prev_o) n_glitch++;
      prev_o = {joy1_out, joy2_out, md_det, six_det};
      if (scan_done === 1'b1) begin
        t_done = c;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic wait_toggles(input int n, output bit ok);
    logic prev;
    int   seen;
    prev = joy_select; seen = 0; ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      step();
      if (joy_select !== prev) seen++;
      prev = joy_select;
      if (seen == n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  int tf, nt, td, ng, bad_pt;
  bit ok;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_sel",  {31'h0, joy_select}, 32'h1);
    check("rst_joy1", {20'h0, joy1_out}, 32'hfff);
    check("rst_joy2", {20'h0, joy2_out}, 32'hfff);
    check("rst_md",   {30'h0, md_det}, 32'h0);
    check("rst_six",  {30'h0, six_det}, 32'h0);
    check("rst_done", {31'h0, scan_done}, 32'h0);

    // No pad: first scan timing after reset release, then the steady period
    push(12'hfff, 12'hfff, 2'b00, 2'b00);
    rst_n = 1'b1;
    measure_scan(tf, nt, td, ng);
    check("first_fall", tf, POLL + SEL);
    check("toggles", nt, 8);
    check("first_done", td, SCAN_T);
    check("glitch0", ng, 0);
    push(12'hfff, 12'hfff, 2'b00, 2'b00);
    measure_scan(tf, nt, td, ng);
    check("period", td, SCAN_T);
    check("fall_to_done", td - tf, 7 * SEL + 1);

    // Atari pad: fire1 + up held
    raw1 = 6'h27;
    push(12'hfe7, 12'hfff, 2'b00, 2'b00);
    measure_scan(tf, nt, td, ng);
    check("atari_done", td, SCAN_T);

    // 3-button pad: A + Start + right
    kind1 = 1; btn1 = 12'hf3e;
    push(12'hf3e, 12'hfff, 2'b01, 2'b00);
    measure_scan(tf, nt, td, ng);
    check("md3_glitch", ng, 0);

    // 6-button pad on port 2 only: X + Mode
    kind1 = 0; raw1 = 6'h3f; kind2 = 2; btn2 = 12'h3ff;
    push(12'hfff, 12'h3ff, 2'b10, 2'b10);
    measure_scan(tf, nt, td, ng);
    check("md6_done", td, SCAN_T);

    // 6-button B+Z+left on port 1, 3-button C+down on port 2
    kind1 = 2; btn1 = 12'heed; kind2 = 1; btn2 = 12'hfdb;
    push(12'heed, 12'hfdb, 2'b11, 2'b01);
    measure_scan(tf, nt, td, ng);
    check("mixed_glitch", ng, 0);

    // Async reset during p4
    wait_toggles(4, ok);
    check("p4_reached", {31'h0, ok}, 32'h1);
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    check("arst_sel",  {31'h0, joy_select}, 32'h1);
    check("arst_joy1", {20'h0, joy1_out}, 32'hfff);
    check("arst_joy2", {20'h0, joy2_out}, 32'hfff);
    check("arst_md",   {30'h0, md_det}, 32'h0);
    repeat (2) @(negedge clk);
    push(12'heed, 12'hfdb, 2'b11, 2'b01);
    rst_n = 1'b1;
    measure_scan(tf, nt, td, ng);
    check("arst_first_fall", tf, POLL + SEL);
    check("arst_first_done", td, SCAN_T);

    // Pass-through mode
    kind1 = 0; raw1 = 6'h3e; en = 1'b0;
    step();
    check("pt_joy1", {20'h0, joy1_out}, 32'hffe);
    check("pt_joy2", {20'h0, joy2_out}, 32'hfdb);
    check("pt_md",   {30'h0, md_det}, 32'h0);
    check("pt_six",  {30'h0, six_det}, 32'h0);
    @(negedge clk);
    raw1 = 6'h15;
    step();
    check("pt_latency", {20'h0, joy1_out}, 32'hfd5);
    bad_pt = 0;
    for (int c = 0; c < 300; c++) begin
      step();
      if (joy_select !== 1'b1 || scan_done !== 1'b0) bad_pt++;
    end
    check("pt_sel_hold", bad_pt, 0);

    // en dropped during p3: that scan still completes and latches
    @(negedge clk);
    kind1 = 1; btn1 = 12'hf3e; en = 1'b1;
    push(12'hf3e, 12'hfdb, 2'b11, 2'b00);
    wait_toggles(3, ok);
    check("p3_reached", {31'h0, ok}, 32'h1);
    @(negedge clk);
    en = 1'b0;
    measure_scan(tf, nt, td, ng);
    check("endrop_done_seen", {31'h0, (td > 0)}, 32'h1);
    step();
    check("endrop_pt_joy1", {20'h0, joy1_out}, 32'hffe);
    check("endrop_pt_md",   {30'h0, md_det}, 32'h0);

    repeat (2) @(negedge clk);
    check("sb_drain", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
